// File: rtl/pe_feeder.sv
// pe_feeder: sequencer feeding a weight-stationary systolic PE array.
// Loads systolic_depth weight rows (is_wt/wt_in), streams activation vectors with a
// per-lane diagonal skew (data_in/lane_valid), then flushes zeros so partial sums drain.
// Optional feature: define PE_FEEDER_BUBBLE_CNT_EN to add the bubble_cnt output, which
// counts STREAM cycles that had no activation accept.
//
// Handshake: a transfer occurs on a rising clk edge where valid && ready are both high.
// ready is a register that depends only on state and counters, never on valid, and the
// producer may change data/valid freely once a transfer has happened. The array side
// cannot stall: every cycle presents a vector, real or zero.
module pe_feeder #(
  parameter int bit_width       = 8,
  parameter int systolic_depth  = 4,
  parameter int systolic_column = 16,
  parameter int cnt_width       = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [cnt_width-1:0]                 num_vec,
  input  logic                                 wt_valid,
  output logic                                 wt_ready,
  input  logic [bit_width*systolic_column-1:0] wt_data,
  input  logic                                 act_valid,
  output logic                                 act_ready,
  input  logic [bit_width*systolic_depth-1:0]  act_data,
  output logic                                 is_wt,
  output logic [bit_width*systolic_column-1:0] wt_in,
  output logic [bit_width*systolic_depth-1:0]  data_in,
  output logic [systolic_depth-1:0]            lane_valid,
  output logic                                 busy,
  output logic                                 done,
`ifdef PE_FEEDER_BUBBLE_CNT_EN
  output logic [cnt_width-1:0]                 bubble_cnt,
`endif
  output logic [2:0]                           state_dbg
);

  // Flush long enough for the last vector to cross the skew and every column.
  localparam int FLUSH_LEN = systolic_depth - 1 + systolic_column;
  localparam int WCW       = $clog2(systolic_depth + 1);
  localparam int FCW       = $clog2(FLUSH_LEN + 1);
  localparam logic [WCW-1:0] WT_LAST    = WCW'(systolic_depth - 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_WT = 3'd1,
    S_STREAM  = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [cnt_width-1:0] nv_q;
  logic [cnt_width-1:0] act_cnt;
  logic [WCW-1:0]       wt_cnt;
  logic [FCW-1:0]       flush_cnt;
  logic                 wt_acc;
  logic                 act_acc;

  assign wt_acc    = wt_valid & wt_ready;
  assign act_acc   = act_valid & act_ready;
  assign state_dbg = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode from the current phase and its counters.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_LOAD_WT;
      S_LOAD_WT: if (wt_acc && wt_cnt == WT_LAST)
                   state_next = (nv_q == '0) ? S_FLUSH : S_STREAM;
      S_STREAM:  if (act_acc && (act_cnt + cnt_width'(1)) == nv_q) state_next = S_FLUSH;
      S_FLUSH:   if (flush_cnt == FLUSH_LAST) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Tile length capture and per-phase counters; each counter idles at zero outside its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      nv_q      <= '0;
      wt_cnt    <= '0;
      act_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) nv_q <= num_vec;
      if (state == S_LOAD_WT) wt_cnt <= wt_cnt + WCW'(wt_acc);
      else                    wt_cnt <= '0;
      if (state == S_STREAM) begin
        if (act_acc) act_cnt <= act_cnt + cnt_width'(1);
      end else begin
        act_cnt <= '0;
      end
      if (state == S_FLUSH) flush_cnt <= flush_cnt + FCW'(1);
      else                  flush_cnt <= '0;
    end
  end

  // Registered control outputs, decoded from the state about to be entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_ready  <= 1'b0;
      act_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      is_wt     <= 1'b0;
      wt_in     <= '0;
    end else begin
      wt_ready  <= (state_next == S_LOAD_WT);
      act_ready <= (state_next == S_STREAM);
      busy      <= (state_next != S_IDLE);
      done      <= (state_next == S_DONE);
      is_wt     <= wt_acc;
      wt_in     <= wt_acc ? wt_data : '0;
    end
  end

  // Per-lane skew: lane r is an input register followed by r delay stages.
  for (genvar r = 0; r < systolic_depth; r++) begin : g_lane
    logic [bit_width-1:0] sd [r+1];
    logic                 sv [r+1];

    // Shift the lane's element and its valid bit together; non-accept cycles inject zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) begin
          sd[k] <= '0;
          sv[k] <= 1'b0;
        end
      end else begin
        sd[0] <= act_acc ? act_data[bit_width*r +: bit_width] : '0;
        sv[0] <= act_acc;
        for (int k = 1; k <= r; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign data_in[bit_width*r +: bit_width] = sd[r];
    assign lane_valid[r]                     = sv[r];
  end

`ifdef PE_FEEDER_BUBBLE_CNT_EN
  // Saturating count of STREAM cycles that injected a zero vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      bubble_cnt <= '0;
    end else if (state == S_STREAM && !act_acc && bubble_cnt != '1) begin
      bubble_cnt <= bubble_cnt + cnt_width'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Testbench for pe_feeder. Each tile's stimulus is laid out per cycle in arrays; a
// timeline model derives the accept cycles from the valids and the phase rules, and from
// that the expected outputs of every cycle. One compare process checks them each cycle.
module tb_pe_feeder;
  localparam int BW    = 8;
  localparam int SD    = 4;
  localparam int SC    = 16;
  localparam int CW    = 16;
  localparam int WW    = BW * SC;
  localparam int AW    = BW * SD;
  localparam int FLUSH = SD - 1 + SC;
  localparam int MAXC  = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_vec;
  logic          wt_valid;
  logic          wt_ready;
  logic [WW-1:0] wt_data;
  logic          act_valid;
  logic          act_ready;
  logic [AW-1:0] act_data;
  logic          is_wt;
  logic [WW-1:0] wt_in;
  logic [AW-1:0] data_in;
  logic [SD-1:0] lane_valid;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;
`ifdef PE_FEEDER_BUBBLE_CNT_EN
  logic [CW-1:0] bubble_cnt;
`endif

  pe_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .wt_data    (wt_data),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .act_data   (act_data),
    .is_wt      (is_wt),
    .wt_in      (wt_in),
    .data_in    (data_in),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done),
`ifdef PE_FEEDER_BUBBLE_CNT_EN
    .bubble_cnt (bubble_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic          wt_ready;
    logic          act_ready;
    logic          is_wt;
    logic          busy;
    logic          done;
    logic [2:0]    state;
    logic [WW-1:0] wt_in;
    logic [AW-1:0] data_in;
    logic [SD-1:0] lane_valid;
    logic [CW-1:0] bubble;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int   compared   = 0;
  int   mismatched = 0;

  // Per-cycle stimulus of the current tile (index = cycle, 0 = the start cycle).
  bit            st_a [MAXC];
  bit            wv_a [MAXC];
  bit            av_a [MAXC];
  logic [WW-1:0] wd_a [MAXC];
  logic [AW-1:0] ad_a [MAXC];
  logic [CW-1:0] nv_a [MAXC];

  // Timeline of the current tile.
  int            w_acc [SD];
  int            a_acc [$];
  int            w_last;
  int            last_c;
  int            done_c;
  int            tl_nv;
  logic [CW-1:0] idle_bubble;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Accept cycles: first SD cycles after start with wt_valid, then the first nv cycles
  // after the last row with act_valid; flush runs FLUSH cycles after the last accept.
  function automatic void build_timeline(input int nv);
    int n;
    int c;
    n = 0;
    tl_nv = nv;
    a_acc.delete();
    c = 1;
    while (n < SD && c < MAXC) begin
      if (wv_a[c]) begin
        w_acc[n] = c;
        n++;
      end
      c++;
    end
    w_last = w_acc[SD-1];
    c = w_last + 1;
    while (a_acc.size() < nv && c < MAXC) begin
      if (av_a[c]) a_acc.push_back(c);
      c++;
    end
    last_c = (nv > 0) ? a_acc[nv-1] : w_last;
    done_c = last_c + FLUSH + 1;
  endfunction

  // Expected outputs visible during cycle k of the current tile (k >= 1).
  function automatic exp_t exp_at(input int k);
    exp_t e;
    int   st;
    int   b;
    e = '0;
    b = 0;
    if (k == 0 || k > done_c) st = 0;
    else if (k <= w_last)     st = 1;
    else if (k <= last_c)     st = 2;
    else if (k < done_c)      st = 3;
    else                      st = 4;
    e.state     = 3'(st);
    e.wt_ready  = (st == 1);
    e.act_ready = (st == 2);
    e.busy      = (st != 0);
    e.done      = (st == 4);
    for (int i = 0; i < SD; i++) begin
      if (w_acc[i] + 1 == k) begin
        e.is_wt = 1'b1;
        e.wt_in = wd_a[w_acc[i]];
      end
    end
    for (int j = 0; j < a_acc.size(); j++) begin
      for (int r = 0; r < SD; r++) begin
        if (a_acc[j] + 1 + r == k) begin
          e.data_in[BW*r +: BW] = ad_a[a_acc[j]][BW*r +: BW];
          e.lane_valid[r]       = 1'b1;
        end
      end
    end
    if (tl_nv > 0) begin
      for (int q = w_last + 1; q < k && q <= last_c; q++) begin
        if (!av_a[q]) b++;
      end
    end
    e.bubble = CW'(b);
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.bubble = idle_bubble;
    return e;
  endfunction

  task automatic fill_random(input int pw, input int pa, input bit hold_start);
    for (int c = 0; c < MAXC; c++) begin
      st_a[c] = hold_start ? 1'b1 : ($urandom_range(0, 3) == 0);
      wv_a[c] = (c >= 200) || ($urandom_range(0, 99) < pw);
      av_a[c] = (c >= 200) || ($urandom_range(0, 99) < pa);
      wd_a[c] = {$urandom, $urandom, $urandom, $urandom};
      ad_a[c] = $urandom;
      nv_a[c] = CW'($urandom);
    end
  endtask

  // Literal rows 0x11..0x44 in cycles 1..4 and vectors {1,2,3,4},{5,6,7,8},... from cycle vc.
  task automatic fill_directed(input int vc);
    logic [BW-1:0] b;
    fill_random(100, 100, 1'b0);
    for (int i = 0; i < SD; i++) begin
      b = BW'(8'h11 * (i + 1));
      wd_a[1 + i] = {SC{b}};
    end
    for (int j = 0; j < 8; j++) ad_a[vc + j] = {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)};
  endtask

  task automatic drive(input int c, input bit do_rst);
    rst       = do_rst;
    start     = st_a[c];
    num_vec   = nv_a[c];
    wt_valid  = wv_a[c];
    wt_data   = wd_a[c];
    act_valid = av_a[c];
    act_data  = ad_a[c];
  endtask

  // Drive one tile starting from an IDLE cycle; rst_at >= 1 aborts it with reset.
  task automatic run_tile(input int nv, input int rst_at);
    st_a[0] = 1'b1;
    nv_a[0] = CW'(nv);
    build_timeline(nv);
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      drive(c, c == rst_at);
      if (c == rst_at) begin
        idle_bubble = '0;
        exp_q.push_back(idle_exp());
        return;
      end
      exp_q.push_back(exp_at(c + 1));
    end
    cmp_e = exp_at(done_c + 1);
    idle_bubble = cmp_e.bubble;
  endtask

  task automatic idle(input int n, input bit do_rst);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = do_rst;
      start     = 1'b0;
      num_vec   = CW'($urandom);
      wt_valid  = 1'($urandom_range(0, 1));
      wt_data   = {$urandom, $urandom, $urandom, $urandom};
      act_valid = 1'($urandom_range(0, 1));
      act_data  = $urandom;
      if (do_rst) idle_bubble = '0;
      exp_q.push_back(idle_exp());
    end
  endtask

  // Scoreboard: compare every cycle's outputs against the model.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      check("state", state_dbg, cmp_e.state);
      check("wt_ready", wt_ready, cmp_e.wt_ready);
      check("act_ready", act_ready, cmp_e.act_ready);
      check("busy", busy, cmp_e.busy);
      check("done", done, cmp_e.done);
      check("is_wt", is_wt, cmp_e.is_wt);
      if (cmp_e.is_wt) check("wt_in", wt_in, cmp_e.wt_in);
      check("data_in", data_in, cmp_e.data_in);
      check("lane_valid", lane_valid, cmp_e.lane_valid);
`ifdef PE_FEEDER_BUBBLE_CNT_EN
      check("bubble_cnt", bubble_cnt, cmp_e.bubble);
`endif
    end
  end

  exp_t pe;
  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0; wt_valid = 1'b0; wt_data = '0;
    act_valid = 1'b0; act_data = '0; idle_bubble = '0;
    idle(3, 1'b1);
    idle(2, 1'b0);

    // Basic tile: 4 rows, 3 vectors, all back-to-back.
    fill_directed(5);
    run_tile(3, -1);
    check("pin_basic_done_cycle", 128'(done_c), 128'd27);
    pe = exp_at(6);  check("pin_lane0_v0", pe.data_in[7:0], 8'd1);
    pe = exp_at(8);  check("pin_lane0_v2", pe.data_in[7:0], 8'd9);
    pe = exp_at(9);  check("pin_lane3_v0", pe.data_in[31:24], 8'd4);
    pe = exp_at(11); check("pin_lane3_v2", pe.data_in[31:24], 8'd12);
    pe = exp_at(3);  check("pin_row1", pe.wt_in, {SC{8'h22}});
    idle(2, 1'b0);

    // Two bubbles between vectors 1 and 2.
    fill_directed(5);
    av_a[6] = 1'b0; av_a[7] = 1'b0;
    ad_a[8] = 32'h08070605; ad_a[9] = 32'h0c0b0a09;
    run_tile(3, -1);
    check("pin_bubble_total", idle_bubble, 16'd2);
    pe = exp_at(7); check("pin_gap_lanes_c7", pe.lane_valid, 4'b0010);
    pe = exp_at(8); check("pin_gap_lanes_c8", pe.lane_valid, 4'b0100);
    idle(2, 1'b0);

    // Weight stalls on alternate cycles.
    fill_directed(9);
    for (int c = 1; c < 12; c++) wv_a[c] = c[0];
    wd_a[3] = {SC{8'h22}}; wd_a[5] = {SC{8'h33}}; wd_a[7] = {SC{8'h44}};
    run_tile(2, -1);
    check("pin_stall_last_row", 128'(w_last), 128'd7);
    idle(2, 1'b0);

    // Empty tile.
    fill_directed(5);
    run_tile(0, -1);
    check("pin_empty_done_cycle", 128'(done_c), 128'd24);
    idle(2, 1'b0);

    // Reset one cycle after the first of three vectors, then a clean tile.
    fill_directed(5);
    run_tile(3, 6);
    idle(3, 1'b0);
    fill_directed(5);
    run_tile(3, -1);
    idle(1, 1'b0);

    // Long tile exercising the upper counter bits.
    fill_random(100, 100, 1'b0);
    run_tile(260, -1);
    idle(1, 1'b0);

    // start held high: tiles chain only through IDLE.
    fill_random(70, 70, 1'b1);
    run_tile(5, -1);
    fill_random(70, 70, 1'b1);
    run_tile(2, -1);
    idle(2, 1'b0);

    // Random tiles with random stalls, held start and occasional resets.
    for (int t = 0; t < 14; t++) begin
      int nv;
      int ra;
      bit hold;
      nv   = $urandom_range(0, 12);
      hold = 1'($urandom_range(0, 1));
      ra   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : -1;
      fill_random($urandom_range(40, 100), $urandom_range(40, 100), hold);
      run_tile(nv, ra);
      if (!hold || ra >= 0) idle($urandom_range(1, 3), 1'b0);
    end

    idle(4, 1'b0);
    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
